fetch_btb: RTL and testbench

FETCH_BTB -- requirements
Module: fetch_btb

---
 rtl/fetch_btb_pkg.sv | 38 +++
 rtl/fetch_btb_if.sv | 36 +++
 rtl/fetch_btb_btb_table.sv | 88 ++++++++
 rtl/fetch_btb.sv | 106 ++++++++++
 tb/tb_fetch_btb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_btb_pkg.sv
// Shared definitions for the fetch stage: 2-bit branch counter encoding,
// default word size and small helper functions.
package fetch_btb_pkg;

  localparam int WORD_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Saturating up/down step of a 2-bit prediction counter.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    if (taken) begin
      nxt = (cur == ST) ? ST : ctr_e'(cur + 2'd1);
    end else begin
      nxt = (cur == SNT) ? SNT : ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_btb_if.sv
// Fetch-stage bus: instruction memory port, IF/ID outputs and EX feedback.
// master = fetch unit, slave = surrounding pipeline / memory.
interface fetch_btb_if #(
  parameter int WORD_SIZE = fetch_btb_pkg::WORD_SIZE_DEF
);
  logic                 stall;
  logic                 readM1;
  logic [WORD_SIZE-1:0] address1;
  logic [WORD_SIZE-1:0] data1;
  logic                 inst_valid;
  logic [WORD_SIZE-1:0] inst_out;
  logic [WORD_SIZE-1:0] pc_plus1_out;
  logic                 pred_taken;
  logic [WORD_SIZE-1:0] pred_target;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic [WORD_SIZE-1:0] resolve_pc;
  logic [WORD_SIZE-1:0] resolve_target;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic [WORD_SIZE-1:0] fetch_count;

  modport master (
    input  stall, data1, resolve_valid, resolve_taken, resolve_pc,
           resolve_target, redirect, redirect_pc,
    output readM1, address1, inst_valid, inst_out, pc_plus1_out,
           pred_taken, pred_target, fetch_count
  );

  modport slave (
    output stall, data1, resolve_valid, resolve_taken, resolve_pc,
           resolve_target, redirect, redirect_pc,
    input  readM1, address1, inst_valid, inst_out, pc_plus1_out,
           pred_taken, pred_target, fetch_count
  );
endinterface

// File: rtl/fetch_btb_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup of the current
// entry contents, one registered update per cycle from EX resolution.
module btb_table
  import fetch_btb_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] lookup_pc_i,
  output logic                 lookup_hit_o,
  output ctr_e                 lookup_ctr_o,
  output logic [WORD_SIZE-1:0] lookup_target_o,
  input  logic                 upd_valid_i,
  input  logic                 upd_taken_i,
  input  logic [WORD_SIZE-1:0] upd_pc_i,
  input  logic [WORD_SIZE-1:0] upd_target_i
);

  localparam int IDX_W = clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD_SIZE - IDX_W;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [WORD_SIZE-1:0] target;
    ctr_e                 ctr;
  } entry_t;

  entry_t             tbl_q [BTB_ENTRIES];
  entry_t             look_entry_s;
  entry_t             upd_entry_s;
  entry_t             upd_entry_d;
  logic               upd_hit_s;
  logic               upd_we_s;
  logic [IDX_W-1:0]   look_idx_s;
  logic [IDX_W-1:0]   upd_idx_s;
  logic [TAG_W-1:0]   upd_tag_s;

  assign look_idx_s      = lookup_pc_i[IDX_W-1:0];
  assign look_entry_s    = tbl_q[look_idx_s];
  assign lookup_hit_o    = look_entry_s.valid &&
                           (look_entry_s.tag == lookup_pc_i[WORD_SIZE-1:IDX_W]);
  assign lookup_ctr_o    = look_entry_s.ctr;
  assign lookup_target_o = look_entry_s.target;

  assign upd_idx_s   = upd_pc_i[IDX_W-1:0];
  assign upd_tag_s   = upd_pc_i[WORD_SIZE-1:IDX_W];
  assign upd_entry_s = tbl_q[upd_idx_s];
  assign upd_hit_s   = upd_entry_s.valid && (upd_entry_s.tag == upd_tag_s);

  // Resolution: train on hit, allocate on taken miss, ignore not-taken miss.
  always_comb begin
    upd_entry_d = upd_entry_s;
    upd_we_s    = 1'b0;
    if (upd_valid_i) begin
      if (upd_hit_s) begin
        upd_we_s        = 1'b1;
        upd_entry_d.ctr = ctr_next(upd_entry_s.ctr, upd_taken_i);
        if (upd_taken_i) begin
          upd_entry_d.target = upd_target_i;
        end else begin
          upd_entry_d.target = upd_entry_s.target;
        end
      end else if (upd_taken_i) begin
        upd_we_s    = 1'b1;
        upd_entry_d = '{valid: 1'b1, tag: upd_tag_s, target: upd_target_i, ctr: WT};
      end else begin
        upd_we_s = 1'b0;
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Table storage; writes land at the edge so same-cycle lookups see old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (upd_we_s) begin
      tbl_q[upd_idx_s] <= upd_entry_d;
    end
  end

endmodule

// File: rtl/fetch_btb.sv
// Fetch stage with PC, IF/ID register and optional BTB predictor.
// Define FETCH_BTB_EN to build the branch target buffer.
module fetch_btb
  import fetch_btb_pkg::*;
#(
  parameter int                   WORD_SIZE   = WORD_SIZE_DEF,
  parameter int                   BTB_ENTRIES = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic       clk,
  input  logic       rst,
  fetch_btb_if.master bus
);

  localparam logic [WORD_SIZE-1:0] PC_INC = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] pc1;
    logic                 ptk;
    logic [WORD_SIZE-1:0] ptg;
  } ifid_t;

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] cnt_q, cnt_d;
  ifid_t                ifid_q, ifid_d;
  logic [WORD_SIZE-1:0] pc_plus1_s;
  logic                 pred_taken_s;
  logic [WORD_SIZE-1:0] pred_target_s;

  assign pc_plus1_s = pc_q + PC_INC;

`ifdef FETCH_BTB_EN
  logic                 btb_hit_s;
  ctr_e                 btb_ctr_s;
  logic [WORD_SIZE-1:0] btb_target_s;

  btb_table #(
    .WORD_SIZE   (WORD_SIZE),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc_i     (pc_q),
    .lookup_hit_o    (btb_hit_s),
    .lookup_ctr_o    (btb_ctr_s),
    .lookup_target_o (btb_target_s),
    .upd_valid_i     (bus.resolve_valid),
    .upd_taken_i     (bus.resolve_taken),
    .upd_pc_i        (bus.resolve_pc),
    .upd_target_i    (bus.resolve_target)
  );

  assign pred_taken_s  = btb_hit_s && (btb_ctr_s >= WT);
  assign pred_target_s = pred_taken_s ? btb_target_s : pc_plus1_s;
`else
  logic unused_resolve_s;

  assign unused_resolve_s = ^{bus.resolve_valid, bus.resolve_taken,
                              bus.resolve_pc, bus.resolve_target};
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = pc_plus1_s;
`endif

  // Next-PC and IF/ID selection: redirect beats stall beats normal fetch.
  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (bus.redirect) begin
      pc_d         = bus.redirect_pc;
      ifid_d.valid = 1'b0;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      pc_d   = pred_taken_s ? pred_target_s : pc_plus1_s;
      ifid_d = '{valid: 1'b1, inst: bus.data1, pc1: pc_plus1_s,
                 ptk: pred_taken_s, ptg: pred_target_s};
      cnt_d  = cnt_q + PC_INC;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      ifid_q <= '0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.readM1       = 1'b1;
  assign bus.address1     = pc_q;
  assign bus.inst_valid   = ifid_q.valid;
  assign bus.inst_out     = ifid_q.inst;
  assign bus.pc_plus1_out = ifid_q.pc1;
  assign bus.pred_taken   = ifid_q.ptk;
  assign bus.pred_target  = ifid_q.ptg;
  assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_btb.sv
// Scoreboard bench for fetch_btb; expectations follow FETCH_BTB_EN.
module tb_fetch_btb;
  import fetch_btb_pkg::*;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        valid;
    logic        chk_data;
    logic [15:0] inst;
    logic [15:0] pc1;
    logic        ptk;
    logic [15:0] ptg;
    logic [15:0] cnt;
  } exp_t;

  logic   clk;
  logic   rst;
  logic   mon_en;
  int     n_checks;
  int     n_errors;
  exp_t   exp_q[$];

  fetch_btb_if #(.WORD_SIZE(16)) bus ();

  fetch_btb #(
    .WORD_SIZE   (16),
    .BTB_ENTRIES (16),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.data1 = 16'h1000 + bus.address1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_readM1"},      {15'd0, bus.readM1},     16'h0001);
    chk({tag, "_address1"},    bus.address1,            16'h0000);
    chk({tag, "_inst_valid"},  {15'd0, bus.inst_valid}, 16'h0000);
    chk({tag, "_inst_out"},    bus.inst_out,            16'h0000);
    chk({tag, "_pc_plus1"},    bus.pc_plus1_out,        16'h0000);
    chk({tag, "_pred_taken"},  {15'd0, bus.pred_taken}, 16'h0000);
    chk({tag, "_pred_target"}, bus.pred_target,         16'h0000);
    chk({tag, "_fetch_count"}, bus.fetch_count,         16'h0000);
  endtask

  // One cycle of stimulus; the state expected after the next rising edge is queued.
  task automatic cyc(input logic st, input logic rd, input logic [15:0] rpc,
                     input logic rv, input logic rt, input logic [15:0] rp,
                     input logic [15:0] rtg, input logic [15:0] e_addr,
                     input logic e_valid, input logic e_chk, input logic [15:0] e_inst,
                     input logic [15:0] e_pc1, input logic e_ptk,
                     input logic [15:0] e_ptg, input logic [15:0] e_cnt);
    exp_t e;
    bus.stall          = st;
    bus.redirect       = rd;
    bus.redirect_pc    = rpc;
    bus.resolve_valid  = rv;
    bus.resolve_taken  = rt;
    bus.resolve_pc     = rp;
    bus.resolve_target = rtg;
    e = '{addr: e_addr, valid: e_valid, chk_data: e_chk, inst: e_inst,
          pc1: e_pc1, ptk: e_ptk, ptg: e_ptg, cnt: e_cnt};
    exp_q.push_back(e);
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pop one expectation per clock and compare against the DUT.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        e = exp_q.pop_front();
        chk("address1",    bus.address1,            e.addr);
        chk("inst_valid",  {15'd0, bus.inst_valid}, {15'd0, e.valid});
        chk("fetch_count", bus.fetch_count,         e.cnt);
        chk("readM1",      {15'd0, bus.readM1},     16'h0001);
        if (e.chk_data) begin
          chk("inst_out",    bus.inst_out,            e.inst);
          chk("pc_plus1",    bus.pc_plus1_out,        e.pc1);
          chk("pred_taken",  {15'd0, bus.pred_taken}, {15'd0, e.ptk});
          chk("pred_target", bus.pred_target,         e.ptg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
    bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0;
    bus.resolve_pc = 16'h0000; bus.resolve_target = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    // Sequential fetch from RESET_PC
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0001, 1, 1, 16'h1000, 16'h0001, 0, 16'h0001, 16'd1);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0002, 1, 1, 16'h1001, 16'h0002, 0, 16'h0002, 16'd2);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0003, 1, 1, 16'h1002, 16'h0003, 0, 16'h0003, 16'd3);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0004, 1, 1, 16'h1003, 16'h0004, 0, 16'h0004, 16'd4);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0005, 1, 1, 16'h1004, 16'h0005, 0, 16'h0005, 16'd5);
    // Two-cycle stall at PC 5
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0005, 1, 1, 16'h1004, 16'h0005, 0, 16'h0005, 16'd5);
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0005, 1, 1, 16'h1004, 16'h0005, 0, 16'h0005, 16'd5);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0006, 1, 1, 16'h1005, 16'h0006, 0, 16'h0006, 16'd6);
    // Redirect together with stall
    cyc(1, 1, 16'h0040, 0, 0, 16'h0, 16'h0, 16'h0040, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd6);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0041, 1, 1, 16'h1040, 16'h0041, 0, 16'h0041, 16'd7);
    // Taken resolve at 0x0003 allocates, then fetch 0x0003
    cyc(0, 1, 16'h0003, 1, 1, 16'h0003, 16'h0020, 16'h0003, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd7);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, BTB_ON ? 16'h0020 : 16'h0004, 1, 1, 16'h1003, 16'h0004,
        BTB_ON, BTB_ON ? 16'h0020 : 16'h0004, 16'd8);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, BTB_ON ? 16'h0021 : 16'h0005, 1, 1,
        BTB_ON ? 16'h1020 : 16'h1004, BTB_ON ? 16'h0021 : 16'h0005, 0,
        BTB_ON ? 16'h0021 : 16'h0005, 16'd9);
    // Two not-taken resolves: WT -> WNT -> SNT
    cyc(0, 1, 16'h0003, 1, 0, 16'h0003, 16'h0, 16'h0003, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd9);
    cyc(0, 1, 16'h0003, 1, 0, 16'h0003, 16'h0, 16'h0003, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd9);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0004, 1, 1, 16'h1003, 16'h0004, 0, 16'h0004, 16'd10);
    // Alias: 0x0013 shares index 3, replaces the 0x0003 entry
    cyc(0, 1, 16'h0013, 1, 1, 16'h0013, 16'h0050, 16'h0013, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd10);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, BTB_ON ? 16'h0050 : 16'h0014, 1, 1, 16'h1013, 16'h0014,
        BTB_ON, BTB_ON ? 16'h0050 : 16'h0014, 16'd11);
    cyc(0, 1, 16'h0003, 0, 0, 16'h0, 16'h0, 16'h0003, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd11);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0004, 1, 1, 16'h1003, 16'h0004, 0, 16'h0004, 16'd12);
    // PC+1 wraps at the top of the address space
    cyc(0, 1, 16'hFFFF, 0, 0, 16'h0, 16'h0, 16'hFFFF, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd12);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0000, 1, 1, 16'h0FFF, 16'h0000, 0, 16'h0000, 16'd13);
    // Lookup and update of the same index in one cycle sees the old counter
    cyc(0, 1, 16'h0013, 0, 0, 16'h0, 16'h0, 16'h0013, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'd13);
    cyc(0, 0, 16'h0, 1, 0, 16'h0013, 16'h0, BTB_ON ? 16'h0050 : 16'h0014, 1, 1, 16'h1013, 16'h0014,
        BTB_ON, BTB_ON ? 16'h0050 : 16'h0014, 16'd14);
    mon_en = 1'b0;
    chk("queue_drained", exp_q.size() == 0 ? 16'h0001 : 16'h0000, 16'h0001);
    // Reset asserted while stall and redirect are both active
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 16'h0077;
    bus.resolve_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    @(posedge clk);
    #1;
    check_reset("held_reset");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
